// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: field widths,
// write-back select encodings and FSM state encodings.
package hazard_ctrl_pkg;

    localparam int WIDTH_REGMARK = 5;
    localparam int WIDTH_RegWE   = 1;
    localparam int WIDTH_RWSel   = 2;

    localparam logic [WIDTH_RWSel-1:0] RWSEL_DRAM = 2'd1;

    localparam int SAT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } hz_state_e;

endpackage

// File: rtl/hazard_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module hazard_sat_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [SAT_W-1:0] cnt
);

    logic [SAT_W-1:0] cnt_q;
    logic [SAT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && (cnt_q != {SAT_W{1'b1}})) begin
            cnt_nxt = cnt_q + {{(SAT_W-1){1'b0}}, 1'b1};
        end
    end

    // Written every cycle so the stored value always tracks cnt_nxt.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and post-redirect front-end
// squash, with saturating event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_REGMARK-1:0] id_rs1,
    input  logic                     id_rs1_used,
    input  logic [WIDTH_REGMARK-1:0] id_rs2,
    input  logic                     id_rs2_used,
    input  logic [WIDTH_REGMARK-1:0] ex_RegWr,
    input  logic [WIDTH_RegWE-1:0]   ex_RegWe,
    input  logic [WIDTH_RWSel-1:0]   ex_RWSel,
    input  logic                     ex_redirect,
    output logic                     stop_PC,
    output logic                     stop_IF,
    output logic                     flush_IF,
    output logic                     stop_ID,
    output logic [1:0]               state_o,
    output logic [SAT_W-1:0]         stall_cnt,
    output logic [SAT_W-1:0]         flush_cnt
);

    localparam logic [2:0] SQ_LOAD = 3'(FLUSH_CYC - 1);

    hz_state_e  state;
    logic [2:0] sq_cnt;
    logic       load_use;
    logic       redirect_ev;
    logic       stall_ev;

    always_comb begin
        load_use = (|ex_RegWe) && (ex_RWSel == RWSEL_DRAM) && (ex_RegWr != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_RegWr)) ||
                    (id_rs2_used && (id_rs2 == ex_RegWr)));
    end

    // Events are only honoured in RUN; in FLUSH the EX stage holds a bubble.
    assign redirect_ev = !rst && (state == ST_RUN) && ex_redirect;
    assign stall_ev    = !rst && (state == ST_RUN) && !ex_redirect && load_use;

    always_comb begin
        stop_PC  = 1'b0;
        stop_IF  = 1'b0;
        flush_IF = 1'b0;
        stop_ID  = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        flush_IF = 1'b1;
                        stop_ID  = 1'b1;
                    end else if (load_use) begin
                        stop_PC  = 1'b1;
                        stop_IF  = 1'b1;
                        stop_ID  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_IF = 1'b1;
                    stop_ID  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The redirect cycle is itself the first squash cycle, so FLUSH lasts
    // FLUSH_CYC-1 further cycles and is skipped entirely when that is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_redirect && (SQ_LOAD != 3'd0)) begin
                        state  <= ST_FLUSH;
                        sq_cnt <= SQ_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (sq_cnt <= 3'd1) begin
                        state  <= ST_RUN;
                        sq_cnt <= '0;
                    end else begin
                        sq_cnt <= sq_cnt - 3'd1;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    sq_cnt <= '0;
                end
            endcase
        end
    end

    assign state_o = state;

    hazard_sat_cnt u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall_ev),
        .cnt (stall_cnt)
    );

    hazard_sat_cnt u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (redirect_ev),
        .cnt (flush_cnt)
    );

endmodule
